spike_detector: RTL and testbench

SPIKE_DETECTOR -- requirements
Module: spike_detector

---
 rtl/detector_pkg.sv | 24 ++
 rtl/spike_detector_if.sv | 26 ++
 rtl/spike_detector_neo_core.sv | 96 +++++++++
 rtl/spike_detector.sv | 87 ++++++++
 tb/tb_spike_detector.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/detector_pkg.sv
// Shared widths and helpers for the spike detector slice.
package detector_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int NEO_W         = 32;
  localparam int EMA_SHIFT_DEF = 6;
  localparam int MULT_W        = 8;
  localparam int MEAN_W        = NEO_W + 1;
  localparam int THR_PROD_W    = NEO_W + MULT_W;

  localparam logic [NEO_W-1:0] NEO_MAX = '1;

  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_ONE   = 2'd1,
    FILL_TWO   = 2'd2,
    FILL_FULL  = 2'd3
  } fill_t;

  function automatic logic [NEO_W-1:0] sat_thr(input logic [THR_PROD_W-1:0] p);
    return (|p[THR_PROD_W-1:NEO_W]) ? NEO_MAX : p[NEO_W-1:0];
  endfunction

endpackage

// File: rtl/spike_detector_if.sv
// Sample/config/result bundle between a sample source and the spike detector.
interface spike_detector_if
  import detector_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic [NEO_W-1:0]         threshold_in;
  logic [7:0]               refractory_in;
  logic [NEO_W-1:0]         neo_out;
  logic                     neo_valid;
  logic                     detection;

  modport master (
    output sample_in, sample_valid, threshold_in, refractory_in,
    input  neo_out, neo_valid, detection
  );

  modport slave (
    input  sample_in, sample_valid, threshold_in, refractory_in,
    output neo_out, neo_valid, detection
  );

endinterface

// File: rtl/spike_detector_neo_core.sv
// Three-sample window and clamped NEO (x1^2 - x0*x2) datapath.
//
// state      | meaning
// FILL_EMPTY | no sample accepted since reset
// FILL_ONE   | one sample in the window
// FILL_TWO   | two samples in the window
// FILL_FULL  | window full, psi is meaningful
module neo_core
  import detector_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic                     i_valid,
  output logic [NEO_W-1:0]         o_neo,
  output logic                     o_neo_valid
);

  localparam int PSI_W = 2*DATA_W + 1;
  localparam int MAG_W = PSI_W - 1;

  logic signed [DATA_W-1:0] r_x0, r_x1, r_x2;
  logic                     r_acc;
  fill_t                    r_fill, w_fill_nxt;
  logic [NEO_W-1:0]         r_neo;
  logic                     r_neo_valid;

  logic signed [PSI_W-1:0]  w_sq, w_cross, w_psi;
  logic [MAG_W+NEO_W-1:0]   w_mag_ext;
  logic [NEO_W-1:0]         w_neo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fill <= FILL_EMPTY;
    else       r_fill <= w_fill_nxt;
  end

  always_comb begin
    w_fill_nxt = r_fill;
    if (i_valid) begin
      case (r_fill)
        FILL_EMPTY: w_fill_nxt = FILL_ONE;
        FILL_ONE:   w_fill_nxt = FILL_TWO;
        FILL_TWO:   w_fill_nxt = FILL_FULL;
        default:    w_fill_nxt = FILL_FULL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x0  <= '0;
      r_x1  <= '0;
      r_x2  <= '0;
      r_acc <= 1'b0;
    end else begin
      r_acc <= i_valid;
      if (i_valid) begin
        r_x2 <= r_x1;
        r_x1 <= r_x0;
        r_x0 <= i_sample;
      end
    end
  end

  // Products are formed at full psi width so the difference cannot overflow.
  assign w_sq    = PSI_W'(r_x1) * PSI_W'(r_x1);
  assign w_cross = PSI_W'(r_x0) * PSI_W'(r_x2);
  assign w_psi   = w_sq - w_cross;

  assign w_mag_ext = {{NEO_W{1'b0}}, w_psi[MAG_W-1:0]};

  always_comb begin
    w_neo = w_mag_ext[NEO_W-1:0];
    if (w_psi[PSI_W-1])
      w_neo = '0;
    else if (|w_mag_ext[MAG_W+NEO_W-1:NEO_W])
      w_neo = NEO_MAX;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_neo       <= '0;
      r_neo_valid <= 1'b0;
    end else begin
      r_neo_valid <= r_acc && (r_fill == FILL_FULL);
      if (r_acc && (r_fill == FILL_FULL))
        r_neo <= w_neo;
    end
  end

  assign o_neo       = r_neo;
  assign o_neo_valid = r_neo_valid;

endmodule

// File: rtl/spike_detector.sv
// NEO spike detector: threshold compare, refractory blanking and detection pulse.
// Build with ADAPTIVE_THRESH_EN defined for an EMA-scaled adaptive threshold.
module spike_detector
  import detector_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int EMA_SHIFT = EMA_SHIFT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  spike_detector_if.slave  bus
);

  if (EMA_SHIFT < 1 || EMA_SHIFT >= NEO_W) begin : g_bad_shift
    $error("spike_detector: EMA_SHIFT out of range");
  end

  logic [NEO_W-1:0] w_neo;
  logic             w_neo_valid;
  logic [NEO_W-1:0] w_thr;
  logic             w_warm_ok;
  logic             w_fire;
  logic [7:0]       r_refr;
  logic             r_detection;

  neo_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .i_sample    (bus.sample_in),
    .i_valid     (bus.sample_valid),
    .o_neo       (w_neo),
    .o_neo_valid (w_neo_valid)
  );

`ifdef ADAPTIVE_THRESH_EN
  logic [NEO_W-1:0]        r_mean;
  logic [EMA_SHIFT:0]      r_warm;
  logic [THR_PROD_W-1:0]   w_thr_prod;
  logic signed [MEAN_W-1:0] w_diff, w_step, w_mean_nxt;

  // Threshold uses the mean as it stood before this neo value updates it.
  assign w_thr_prod = THR_PROD_W'(r_mean) * THR_PROD_W'(bus.threshold_in[MULT_W-1:0]);
  assign w_thr      = sat_thr(w_thr_prod);
  assign w_warm_ok  = r_warm[EMA_SHIFT];

  assign w_diff     = $signed({1'b0, w_neo}) - $signed({1'b0, r_mean});
  assign w_step     = w_diff >>> EMA_SHIFT;
  assign w_mean_nxt = $signed({1'b0, r_mean}) + w_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mean <= '0;
      r_warm <= '0;
    end else if (w_neo_valid) begin
      r_mean <= w_mean_nxt[NEO_W-1:0];
      if (!r_warm[EMA_SHIFT])
        r_warm <= r_warm + 1'b1;
    end
  end
`else
  assign w_thr     = bus.threshold_in;
  assign w_warm_ok = 1'b1;
`endif

  assign w_fire = w_neo_valid && (w_neo > w_thr) && (r_refr == 8'd0) && w_warm_ok;

  // A fresh detection reloads the blanking window even if a sample lands on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refr      <= '0;
      r_detection <= 1'b0;
    end else begin
      r_detection <= w_fire;
      if (w_fire)
        r_refr <= bus.refractory_in;
      else if (bus.sample_valid && (r_refr != 8'd0))
        r_refr <= r_refr - 8'd1;
    end
  end

  assign bus.neo_out   = w_neo;
  assign bus.neo_valid = w_neo_valid;
  assign bus.detection = r_detection;

endmodule

// File: tb/tb_spike_detector.sv
// Directed bench for spike_detector; checks use immediate assertions.
module tb_spike_detector;
  import detector_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   nv_cnt;
  int   det_cnt;
  longint neo_sum;

  spike_detector_if #(.DATA_W(16)) bus ();

  spike_detector #(.DATA_W(16), .EMA_SHIFT(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    nv_cnt  = 0;
    det_cnt = 0;
    neo_sum = 0;
    forever begin
      @(negedge clk);
      if (bus.neo_valid) begin
        nv_cnt  = nv_cnt + 1;
        neo_sum = neo_sum + longint'(bus.neo_out);
      end
      if (bus.detection) det_cnt = det_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_neo_out", bus.neo_out, 32'd0);
    check("rst_neo_valid", 32'(bus.neo_valid), 32'd0);
    check("rst_detection", 32'(bus.detection), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One spaced sample: accept at E0, check strobe at E1, detection at E2, pulse end at E3.
  task automatic send_chk(input string tag, input logic signed [15:0] s,
                          input logic exp_nv, input logic [31:0] exp_neo, input logic exp_det);
    @(negedge clk);
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_nv"}, 32'(bus.neo_valid), 32'(exp_nv));
    if (exp_nv) check({tag, "_neo"}, bus.neo_out, exp_neo);
    @(posedge clk);
    #1;
    check({tag, "_det"}, 32'(bus.detection), 32'(exp_det));
    @(posedge clk);
    #1;
    check({tag, "_det_end"}, 32'(bus.detection), 32'd0);
  endtask

  task automatic send_b2b(input logic signed [15:0] s);
    @(negedge clk);
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nv0, det0;
    longint sum0;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.sample_in     = '0;
    bus.sample_valid  = 1'b0;
    bus.threshold_in  = 32'd5000;
    bus.refractory_in = 8'd0;
    #1;
    check("async_rst_nv", 32'(bus.neo_valid), 32'd0);
    do_reset();

`ifdef ADAPTIVE_THRESH_EN
    bus.threshold_in  = 32'd8;
    bus.refractory_in = 8'd0;
    det0 = det_cnt;
    for (int i = 0; i < 16; i++) begin
      send_b2b(16'sd20); send_b2b(16'sd0); send_b2b(-16'sd20); send_b2b(16'sd0);
    end
    idle(3);
    check("adp_warmup_quiet", 32'(det_cnt - det0), 32'd0);
    send_b2b(16'sd0); send_b2b(16'sd300); send_b2b(16'sd0); send_b2b(16'sd0);
    idle(4);
    check("adp_mult8_det", 32'(det_cnt - det0), 32'd1);
    bus.threshold_in = 32'd255;
    det0 = det_cnt;
    send_b2b(16'sd10); send_b2b(16'sd55); send_b2b(16'sd0);
    idle(4);
    check("adp_mult255_nodet", 32'(det_cnt - det0), 32'd0);
`else
    // Single spike 0,100,0
    send_chk("sp1", 16'sd0,   1'b0, 32'd0,     1'b0);
    send_chk("sp2", 16'sd100, 1'b0, 32'd0,     1'b0);
    send_chk("sp3", 16'sd0,   1'b1, 32'd10000, 1'b1);

    // Constant input, threshold 0
    do_reset();
    bus.threshold_in = 32'd0;
    for (int i = 0; i < 20; i++)
      send_chk("const50", 16'sd50, (i >= 2), 32'd0, 1'b0);

    // Negative psi clamps, mixed-sign window
    do_reset();
    bus.threshold_in = 32'd5000;
    send_chk("neg1", 16'sd10, 1'b0, 32'd0, 1'b0);
    send_chk("neg2", 16'sd0,  1'b0, 32'd0, 1'b0);
    send_chk("neg3", 16'sd10, 1'b1, 32'd0, 1'b0);
    do_reset();
    send_chk("mix1", -16'sd100, 1'b0, 32'd0,     1'b0);
    send_chk("mix2", 16'sd10,   1'b0, 32'd0,     1'b0);
    send_chk("mix3", 16'sd100,  1'b1, 32'd10100, 1'b1);

    // Strict compare at threshold, then mid-stream threshold change
    do_reset();
    bus.threshold_in = 32'd10000;
    send_chk("eq1", 16'sd0,   1'b0, 32'd0,     1'b0);
    send_chk("eq2", 16'sd100, 1'b0, 32'd0,     1'b0);
    send_chk("eq3", 16'sd0,   1'b1, 32'd10000, 1'b0);
    send_chk("eq4", 16'sd0,   1'b1, 32'd0,     1'b0);
    bus.threshold_in = 32'd9999;
    send_chk("eq5", 16'sd100, 1'b1, 32'd0,     1'b0);
    send_chk("eq6", 16'sd0,   1'b1, 32'd10000, 1'b1);

    // Two spikes three samples apart, refractory 5 then 2
    do_reset();
    bus.threshold_in  = 32'd5000;
    bus.refractory_in = 8'd5;
    send_chk("r5a", 16'sd0,   1'b0, 32'd0,     1'b0);
    send_chk("r5b", 16'sd100, 1'b0, 32'd0,     1'b0);
    send_chk("r5c", 16'sd0,   1'b1, 32'd10000, 1'b1);
    send_chk("r5d", 16'sd0,   1'b1, 32'd0,     1'b0);
    send_chk("r5e", 16'sd100, 1'b1, 32'd0,     1'b0);
    send_chk("r5f", 16'sd0,   1'b1, 32'd10000, 1'b0);
    do_reset();
    bus.refractory_in = 8'd2;
    send_chk("r2a", 16'sd0,   1'b0, 32'd0,     1'b0);
    send_chk("r2b", 16'sd100, 1'b0, 32'd0,     1'b0);
    send_chk("r2c", 16'sd0,   1'b1, 32'd10000, 1'b1);
    send_chk("r2d", 16'sd0,   1'b1, 32'd0,     1'b0);
    send_chk("r2e", 16'sd100, 1'b1, 32'd0,     1'b0);
    send_chk("r2f", 16'sd0,   1'b1, 32'd10000, 1'b1);

    // Back-to-back samples: 8 accepted -> 6 strobes, psi sum 10000+10000+25
    do_reset();
    bus.refractory_in = 8'd0;
    nv0 = nv_cnt; det0 = det_cnt; sum0 = neo_sum;
    send_b2b(16'sd0);  send_b2b(16'sd100); send_b2b(16'sd0); send_b2b(16'sd0);
    send_b2b(16'sd100); send_b2b(16'sd0);  send_b2b(16'sd5); send_b2b(16'sd7);
    idle(4);
    check("b2b_nv_count", 32'(nv_cnt - nv0), 32'd6);
    check("b2b_det_count", 32'(det_cnt - det0), 32'd2);
    check("b2b_neo_sum", 32'(neo_sum - sum0), 32'd20025);

    // Reset mid-stream with sample_valid held high
    send_b2b(16'sd0); send_b2b(16'sd100); send_b2b(16'sd0); send_b2b(16'sd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_neo", bus.neo_out, 32'd0);
    check("mid_rst_nv", 32'(bus.neo_valid), 32'd0);
    check("mid_rst_det", 32'(bus.detection), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_hold_nv", 32'(bus.neo_valid), 32'd0);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    reset = 1'b0;
    send_chk("refill1", 16'sd0,   1'b0, 32'd0,     1'b0);
    send_chk("refill2", 16'sd100, 1'b0, 32'd0,     1'b0);
    send_chk("refill3", 16'sd0,   1'b1, 32'd10000, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
